seg_scan: RTL and testbench

Eight-digit multiplexed seven-segment display driver. It sits directly downstream of the `clock` time-keeping block and consumes that block's 32-bit `dout`: eight 4-bit BCD digits, with the least-significant nibble as the rightmost digit. It snapshots the value once per scan frame, then drives one digit at a time with anti-ghosting blanking. It also supports per-digit blanking, decimal points and blinking for the time-set mode.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_decode.sv | 26 ++
 rtl/seg_scan.sv | 113 +++++++++++
 tb/tb_seg_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the all-off values for the sel/seg buses.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;

endpackage

// File: rtl/seg_decode.sv
// BCD nibble to active-low seven-segment pattern; non-BCD codes show a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    always_comb begin
        o_pattern = SEG_DASH;
        case (i_nibble)
            4'd0: o_pattern = SEG_0;
            4'd1: o_pattern = SEG_1;
            4'd2: o_pattern = SEG_2;
            4'd3: o_pattern = SEG_3;
            4'd4: o_pattern = SEG_4;
            4'd5: o_pattern = SEG_5;
            4'd6: o_pattern = SEG_6;
            4'd7: o_pattern = SEG_7;
            4'd8: o_pattern = SEG_8;
            4'd9: o_pattern = SEG_9;
            default: o_pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver: per-frame input snapshot,
// per-slot blanking window, per-digit blank/blink/decimal-point control.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  sel,
    output logic [7:0]  seg
);

    localparam int DIV_W = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_on;

    logic [31:0]      r_din_f;
    logic [7:0]       r_blank_f;
    logic [7:0]       r_blink_f;
    logic [7:0]       r_dp_f;

    logic [7:0]       r_sel;
    logic [7:0]       r_seg;

    logic [3:0]       w_nibble;
    logic [6:0]       w_pattern;
    logic             w_div_tc;
    logic             w_frame_start;
    logic             w_in_blank;
    logic             w_suppress;
    logic [7:0]       w_sel_nxt;
    logic [7:0]       w_seg_nxt;

    assign w_div_tc      = (r_div_cnt == DIV_LAST);
    assign w_frame_start = (r_digit == 3'd0) && (r_div_cnt == '0);
    assign w_in_blank    = (r_div_cnt < BLANK_END);
    assign w_nibble      = r_din_f[{r_digit, 2'b00} +: 4];
    assign w_suppress    = r_blank_f[r_digit] | (r_blink_f[r_digit] & ~r_blink_on);

    seg_decode u_decode (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    // The blanking window at the start of every slot keeps sel from ever
    // enabling a digit while seg still carries the previous digit's pattern.
    always_comb begin
        w_sel_nxt = SEL_OFF;
        w_seg_nxt = SEG_OFF;
        if (!w_in_blank && !w_suppress) begin
            w_sel_nxt = ~(8'h01 << r_digit);
            w_seg_nxt = {~r_dp_f[r_digit], w_pattern};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit     <= 3'd0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_din_f     <= '0;
            r_blank_f   <= '0;
            r_blink_f   <= '0;
            r_dp_f      <= '0;
            r_sel       <= SEL_OFF;
            r_seg       <= SEG_OFF;
        end else begin
            if (w_div_tc) begin
                r_div_cnt <= '0;
                r_digit   <= r_digit + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end

            if (w_frame_start) begin
                r_din_f   <= din;
                r_blank_f <= blank_mask;
                r_blink_f <= blink_mask;
                r_dp_f    <= dp_mask;
            end

            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign sel = r_sel;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: stimulus queues the expected {sel,seg} of
// every lit slot; a negedge monitor pops and checks each slot as it appears.
module tb_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int BLINK_DIV = 64;
    localparam int FRAME     = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = 32'h0;
    logic [7:0]  blank_mask = 8'h0;
    logic [7:0]  blink_mask = 8'h0;
    logic [7:0]  dp_mask = 8'h0;
    logic [7:0]  sel;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sb[$];
    logic        mon_en = 1'b0;
    logic [7:0]  prev_sel = 8'hFF;
    logic [15:0] cur_exp = 16'hFFFF;

    // Hand-decoded {sel,seg} for digits 0..7 of each test frame.
    // 0: din=12345959, 1: din=00000000, 2: din=0000000A, 3: din=12345959 with dp on digit 2
    localparam logic [15:0] EXP [4][8] = '{
        '{16'hFE90, 16'hFD92, 16'hFB90, 16'hF792, 16'hEF99, 16'hDFB0, 16'hBFA4, 16'h7FF9},
        '{16'hFEC0, 16'hFDC0, 16'hFBC0, 16'hF7C0, 16'hEFC0, 16'hDFC0, 16'hBFC0, 16'h7FC0},
        '{16'hFEBF, 16'hFDC0, 16'hFBC0, 16'hF7C0, 16'hEFC0, 16'hDFC0, 16'hBFC0, 16'h7FC0},
        '{16'hFE90, 16'hFD92, 16'hFB10, 16'hF792, 16'hEF99, 16'hDFB0, 16'hBFA4, 16'h7FF9}
    };

    seg_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .sel        (sel),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue digits first..last of a table frame, skipping digits set in skip.
    task automatic push_frame(input int id, input int first, input int last, input logic [7:0] skip);
        for (int k = first; k <= last; k++)
            if (!skip[k]) sb.push_back(EXP[id][k]);
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check16("reset_out", {sel, seg}, 16'hFFFF);
        end
    endtask

    task automatic start_run();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic finish_run(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check16("queue_drained", 16'(sb.size()), 16'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_sel = 8'hFF;
        end else begin
            check16("one_sel_low", 16'($countones(~sel) <= 1), 16'd1);
            if (sel == 8'hFF)
                check16("dark_seg", {8'h00, seg}, 16'h00FF);
            if (sel != 8'hFF && prev_sel == 8'hFF) begin
                if (sb.size() == 0) begin
                    check16("unexpected_slot", {sel, seg}, 16'hFFFF);
                    cur_exp = 16'hFFFF;
                end else begin
                    cur_exp = sb.pop_front();
                    check16("slot", {sel, seg}, cur_exp);
                end
            end else if (sel != 8'hFF) begin
                check16("slot_hold", {sel, seg}, cur_exp);
            end
            prev_sel = sel;
        end
    end

    initial begin
        // Reset plus scan order: two full frames of 12345959.
        din = 32'h12345959;
        do_reset(3);
        push_frame(0, 0, 7, 8'h00);
        push_frame(0, 0, 7, 8'h00);
        start_run();
        @(posedge clk);
        #1;
        check16("first_after_reset", {sel, seg}, 16'hFFFF);
        finish_run(2 * FRAME);

        // Tearing: din changes during digit 3; frame 0 unchanged, frame 1 all zero.
        din = 32'h12345959;
        do_reset(2);
        push_frame(0, 0, 7, 8'h00);
        push_frame(1, 0, 7, 8'h00);
        start_run();
        repeat (13) @(posedge clk);
        #1;
        din = 32'h00000000;
        finish_run(2 * FRAME + 1 - 13);

        // Invalid nibble shows dash; digit 7 permanently blanked.
        din = 32'h0000000A;
        blank_mask = 8'h80;
        do_reset(2);
        push_frame(2, 0, 7, 8'h80);
        push_frame(2, 0, 7, 8'h80);
        start_run();
        finish_run(2 * FRAME + 1);
        blank_mask = 8'h00;

        // Blink on digits 0/1: visible two frames, dark two frames, visible again; dp on digit 2.
        din = 32'h12345959;
        blink_mask = 8'h03;
        dp_mask = 8'h04;
        do_reset(2);
        push_frame(3, 0, 7, 8'h00);
        push_frame(3, 0, 7, 8'h00);
        push_frame(3, 0, 7, 8'h03);
        push_frame(3, 0, 7, 8'h03);
        push_frame(3, 0, 7, 8'h00);
        start_run();
        finish_run(5 * FRAME + 1);
        blink_mask = 8'h00;
        dp_mask = 8'h00;

        // Mid-frame reset one cycle into digit 5, then fresh snapshot of zeros.
        din = 32'h12345959;
        do_reset(2);
        push_frame(0, 0, 5, 8'h00);
        push_frame(1, 0, 7, 8'h00);
        start_run();
        repeat (22) @(posedge clk);
        #1;
        check16("digit5_lit", {sel, seg}, 16'hDFB0);
        rst = 1'b1;
        din = 32'h00000000;
        @(posedge clk);
        #1;
        check16("midframe_reset_out", {sel, seg}, 16'hFFFF);
        rst = 1'b0;
        finish_run(FRAME + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
